// File: rtl/tensor_core_scheduler.sv
// tensor_core_scheduler
//
// Front-end controller for small_tensor_core. Two requesters each submit one
// 3x3 operation (0 = matmul, 1 = add, 2 = ReLU). The scheduler grants one
// request, latches its operands into holding registers that drive the core,
// pulses the core write-enable (LOAD) and start (START), waits CORE_LATENCY
// cycles (RUN), captures the core result and returns it over a valid/ready
// response channel (RESP). Illegal opcodes (3..7) skip the core and answer
// immediately with a zero result and the error flag set.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready_out is combinational, only asserted in IDLE for the
// arbitration winner while its valid is high. The response payload is held
// stable while resp_valid_out is high and resp_ready_in is low.
//
// Optional feature: define TENSOR_SCHED_ROUND_ROBIN_EN for round-robin
// arbitration. Without it, requester 0 always wins when both are valid.
//
// Ports
//   tensor_core_clock       clock, rising edge
//   reset_n_in              asynchronous active-low reset
//   req_valid_in[1:0]       per-requester request valid
//   req_ready_out[1:0]      request accepted this cycle (one-hot or zero)
//   req_operation_in[5:0]   opcodes, requester i at [3*i +: 3]
//   req_input1_in           operand A, requester i at [9*DW*i +: 9*DW]
//   req_input2_in           operand B, same layout
//   core_write_enable_out   core register file write enable
//   core_start_out          core start pulse
//   core_operation_out      core operation select
//   core_input1_out         held operand A (element k = row*3+col at [DW*k +: DW])
//   core_input2_out         held operand B
//   core_output_in          core result
//   resp_valid_out          response valid
//   resp_ready_in           response consumer ready
//   resp_id_out             requester that owns the response
//   resp_error_out          request carried an illegal opcode
//   resp_result_out         captured 3x3 result
//   busy_out                high in every state except IDLE
module tensor_core_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int CORE_LATENCY = 6
) (
    input  logic                     tensor_core_clock,
    input  logic                     reset_n_in,
    input  logic [1:0]               req_valid_in,
    output logic [1:0]               req_ready_out,
    input  logic [5:0]               req_operation_in,
    input  logic [18*DATA_WIDTH-1:0] req_input1_in,
    input  logic [18*DATA_WIDTH-1:0] req_input2_in,
    output logic                     core_write_enable_out,
    output logic                     core_start_out,
    output logic [2:0]               core_operation_out,
    output logic [9*DATA_WIDTH-1:0]  core_input1_out,
    output logic [9*DATA_WIDTH-1:0]  core_input2_out,
    input  logic [9*DATA_WIDTH-1:0]  core_output_in,
    output logic                     resp_valid_out,
    input  logic                     resp_ready_in,
    output logic                     resp_id_out,
    output logic                     resp_error_out,
    output logic [9*DATA_WIDTH-1:0]  resp_result_out,
    output logic                     busy_out
);

    localparam int MAT_W = 9 * DATA_WIDTH;
    localparam logic [3:0] RUN_LOAD = 4'(CORE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           state;
    logic [3:0]       run_count;
    logic             grant_idx;
    logic             accept;
    logic [2:0]       sel_op;
    logic [MAT_W-1:0] sel_a;
    logic [MAT_W-1:0] sel_b;

    // Arbitration: grant_idx names the winner whenever at least one valid is high.
`ifdef TENSOR_SCHED_ROUND_ROBIN_EN
    // rr_prio = requester that wins a tie; flips to the other side on each accept.
    logic rr_prio;

    always_comb begin
        grant_idx = 1'b0;
        if (req_valid_in == 2'b11) begin
            grant_idx = rr_prio;
        end else if (!req_valid_in[0]) begin
            grant_idx = 1'b1;
        end
    end

    always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rr_prio <= 1'b0;
        end else if (accept) begin
            rr_prio <= ~grant_idx;
        end
    end
`else
    assign grant_idx = ~req_valid_in[0];
`endif

    // Ready is gated by reset so every output reads zero while reset is held.
    assign req_ready_out = (reset_n_in && state == S_IDLE && req_valid_in != 2'b00)
                           ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign accept        = (req_ready_out != 2'b00);

    assign sel_op = grant_idx ? req_operation_in[5:3] : req_operation_in[2:0];
    assign sel_a  = grant_idx ? req_input1_in[2*MAT_W-1:MAT_W] : req_input1_in[MAT_W-1:0];
    assign sel_b  = grant_idx ? req_input2_in[2*MAT_W-1:MAT_W] : req_input2_in[MAT_W-1:0];

    assign busy_out = (state != S_IDLE);

    always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state                 <= S_IDLE;
            run_count             <= 4'd0;
            core_write_enable_out <= 1'b0;
            core_start_out        <= 1'b0;
            core_operation_out    <= 3'd0;
            core_input1_out       <= '0;
            core_input2_out       <= '0;
            resp_valid_out        <= 1'b0;
            resp_id_out           <= 1'b0;
            resp_error_out        <= 1'b0;
            resp_result_out       <= '0;
        end else begin
            // Both core strobes are single-cycle pulses.
            core_write_enable_out <= 1'b0;
            core_start_out        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        resp_id_out     <= grant_idx;
                        core_input1_out <= sel_a;
                        core_input2_out <= sel_b;
                        if (sel_op > 3'd2) begin
                            // Illegal opcode: answer at once, leave the core alone.
                            resp_result_out <= '0;
                            resp_error_out  <= 1'b1;
                            resp_valid_out  <= 1'b1;
                            state           <= S_RESP;
                        end else begin
                            core_operation_out    <= sel_op;
                            resp_error_out        <= 1'b0;
                            core_write_enable_out <= 1'b1;
                            state                 <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    core_start_out <= 1'b1;
                    state          <= S_START;
                end
                S_START: begin
                    run_count <= RUN_LOAD;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (run_count == 4'd0) begin
                        resp_result_out <= core_output_in;
                        resp_valid_out  <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        run_count <= run_count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready_in) begin
                        resp_valid_out <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Testbench for tensor_core_scheduler: behavioural core model, scoreboard of
// expected responses, directed cases plus randomized traffic.
module tb_tensor_core_scheduler;
    localparam int DW  = 8;
    localparam int LAT = 6;
    localparam int MW  = 9 * DW;
    localparam int RW  = MW + 2;   // {id, error, result}

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [5:0]     req_op;
    logic [2*MW-1:0] req_a;
    logic [2*MW-1:0] req_b;
    logic           core_we;
    logic           core_start;
    logic [2:0]     core_op;
    logic [MW-1:0]  core_in1;
    logic [MW-1:0]  core_in2;
    logic [MW-1:0]  core_out;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic           resp_error;
    logic [MW-1:0]  resp_result;
    logic           busy;

    tensor_core_scheduler #(.DATA_WIDTH(DW), .CORE_LATENCY(LAT)) dut (
        .tensor_core_clock    (clk),
        .reset_n_in           (rst_n),
        .req_valid_in         (req_valid),
        .req_ready_out        (req_ready),
        .req_operation_in     (req_op),
        .req_input1_in        (req_a),
        .req_input2_in        (req_b),
        .core_write_enable_out(core_we),
        .core_start_out       (core_start),
        .core_operation_out   (core_op),
        .core_input1_out      (core_in1),
        .core_input2_out      (core_in2),
        .core_output_in       (core_out),
        .resp_valid_out       (resp_valid),
        .resp_ready_in        (resp_ready),
        .resp_id_out          (resp_id),
        .resp_error_out       (resp_error),
        .resp_result_out      (resp_result),
        .busy_out             (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    logic [RW-1:0] exp_q[$];
    int            grant_log[$];
    logic [RW-1:0] last_resp;
    logic          m_prio;
    bit            rr_rand;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    // ---------------- reference model ----------------
    function automatic int sx(input logic [MW-1:0] v, input int idx);
        logic signed [DW-1:0] e;
        e = v[idx*DW +: DW];
        return int'(e);
    endfunction

    function automatic logic [MW-1:0] tensor_op(input logic [2:0] op, input logic [MW-1:0] a,
                                                input logic [MW-1:0] b);
        logic [MW-1:0] r;
        int acc;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                case (op)
                    3'd0: for (int k = 0; k < 3; k++) acc += sx(a, i*3+k) * sx(b, k*3+j);
                    3'd1: acc = sx(a, i*3+j) + sx(b, i*3+j);
                    3'd2: acc = (sx(a, i*3+j) < 0) ? 0 : sx(a, i*3+j);
                    default: acc = 0;
                endcase
                r[(i*3+j)*DW +: DW] = acc[DW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int k = 0; k < 9; k++) m[k*DW +: DW] = DW'($urandom_range(0, 255));
        return m;
    endfunction

    function automatic logic [2:0] rand_op();
        if ($urandom_range(0, 4) == 0) return 3'($urandom_range(3, 7));
        return 3'($urandom_range(0, 2));
    endfunction

    // ---------------- behavioural core ----------------
    // Correct result only in the cycle exactly LAT cycles after start, and only
    // when start followed a write-enable; otherwise the inverted value.
    logic          core_armed;
    logic          core_running;
    int            core_cyc;
    logic [MW-1:0] core_ideal;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_armed   <= 1'b0;
            core_running <= 1'b0;
            core_cyc     <= 0;
        end else if (core_we) begin
            core_armed   <= 1'b1;
            core_running <= 1'b0;
        end else if (core_start && core_armed) begin
            core_armed   <= 1'b0;
            core_running <= 1'b1;
            core_cyc     <= 1;
        end else if (core_running) begin
            core_cyc <= core_cyc + 1;
        end
    end

    always_comb begin
        core_ideal = tensor_op(core_op, core_in1, core_in2);
        core_out   = (core_running && core_cyc == LAT) ? core_ideal : ~core_ideal;
    end

    // random response backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          prev_valid;
        logic          prev_ready;
        logic [RW-1:0] prev_resp;
        logic [RW-1:0] cur;
        logic [RW-1:0] e;
        bit            trk_on;
        bit            trk_legal;
        int            trk_cyc;
        int            trk_exp;
        int            win;
        logic [2:0]    op;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_resp  = '0;
        trk_on     = 1'b0;
        trk_legal  = 1'b0;
        trk_cyc    = 0;
        trk_exp    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                trk_on     = 1'b0;
                exp_q.delete();
                m_prio     = 1'b0;
            end else begin
                cur = {resp_id, resp_error, resp_result};
                if (prev_valid && !prev_ready) begin
                    check("resp_hold_valid", resp_valid, 1);
                    check("resp_hold_payload", cur, prev_resp);
                end
                if (trk_on) begin
                    trk_cyc++;
                    if (resp_valid) begin
                        check("resp_latency", trk_cyc, trk_exp);
                        trk_on = 1'b0;
                    end else begin
                        check("we_pulse", core_we, trk_legal && trk_cyc == 1);
                        check("start_pulse", core_start, trk_legal && trk_cyc == 2);
                        check("busy_in_flight", busy, 1);
                        if (trk_cyc > trk_exp) begin
                            check("resp_latency", trk_cyc, trk_exp);
                            trk_on = 1'b0;
                        end
                    end
                end
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("resp_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_payload", cur, e);
                        last_resp = cur;
                    end
                end
                if (req_ready != 2'b00) begin
`ifdef TENSOR_SCHED_ROUND_ROBIN_EN
                    win = (req_valid == 2'b11) ? int'(m_prio) : (req_valid[0] ? 0 : 1);
`else
                    win = req_valid[0] ? 0 : 1;
`endif
                    check("grant_onehot", req_ready, 2'b01 << win);
                    check("accept_when_idle", (exp_q.size() != 0) || trk_on, 0);
                    grant_log.push_back(req_ready[1] ? 1 : 0);
                    op = req_op[win*3 +: 3];
                    if (op > 3'd2) exp_q.push_back({1'(win), 1'b1, {MW{1'b0}}});
                    else exp_q.push_back({1'(win), 1'b0,
                                          tensor_op(op, req_a[win*MW +: MW], req_b[win*MW +: MW])});
                    trk_on    = 1'b1;
                    trk_cyc   = 0;
                    trk_legal = (op <= 3'd2);
                    trk_exp   = trk_legal ? 3 + LAT : 1;
                    m_prio    = (win == 0);
                end
                prev_valid = resp_valid;
                prev_ready = resp_ready;
                prev_resp  = cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int id, input logic [2:0] op, input logic [MW-1:0] a,
                        input logic [MW-1:0] b);
        int n;
        @(posedge clk);
        #1;
        req_op[id*3 +: 3]  = op;
        req_a[id*MW +: MW] = a;
        req_b[id*MW +: MW] = b;
        req_valid[id]      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 300);
        if (!req_ready[id]) fail_now("send_timeout");
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic send_both(input logic [2:0] op0, input logic [2:0] op1);
        int n;
        @(posedge clk);
        #1;
        req_op    = {op1, op0};
        req_a     = {rand_mat(), rand_mat()};
        req_b     = {rand_mat(), rand_mat()};
        req_valid = 2'b11;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == 2'b00 && n < 300);
        if (req_ready == 2'b00) fail_now("send_both_timeout");
        @(posedge clk);
        #1;
        req_valid = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, |{req_ready, core_we, core_start, core_op, core_in1, core_in2,
                      resp_valid, resp_id, resp_error, resp_result, busy}, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [MW-1:0] ident, seq, threes, m5, relu_a, relu_e, fe;
        int relu_in[9];
        int relu_out[9];
        int arb_exp[4];
        int n;
        relu_in  = '{-1, 2, -3, 4, -5, 6, -7, 8, -128};
        relu_out = '{0, 2, 0, 4, 0, 6, 0, 8, 0};
`ifdef TENSOR_SCHED_ROUND_ROBIN_EN
        arb_exp = '{0, 1, 0, 1};
`else
        arb_exp = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 9; k++) begin
            ident[k*DW +: DW]  = (k % 4 == 0) ? DW'(1) : DW'(0);
            seq[k*DW +: DW]    = DW'(k + 1);
            threes[k*DW +: DW] = DW'(3);
            m5[k*DW +: DW]     = DW'(-5);
            fe[k*DW +: DW]     = DW'(-2);
            relu_a[k*DW +: DW] = DW'(relu_in[k]);
            relu_e[k*DW +: DW] = DW'(relu_out[k]);
        end
        rr_rand    = 1'b0;
        m_prio     = 1'b0;
        last_resp  = '0;
        req_valid  = 2'b00;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        // directed cases
        send(0, 3'd0, ident, seq);
        drain();
        check("matmul_identity", last_resp, {1'b0, 1'b0, seq});
        send(1, 3'd1, threes, m5);
        drain();
        check("add_req1", last_resp, {1'b1, 1'b0, fe});
        send(1, 3'd2, relu_a, rand_mat());
        drain();
        check("relu_req1", last_resp, {1'b1, 1'b0, relu_e});
        send(1, 3'd5, rand_mat(), rand_mat());
        drain();
        check("illegal_op", last_resp, {1'b1, 1'b1, {MW{1'b0}}});

        // both requesters hold valid for four grants
        grant_log.delete();
        @(posedge clk);
        #1;
        req_op    = {3'd1, 3'd0};
        req_a     = {rand_mat(), rand_mat()};
        req_b     = {rand_mat(), rand_mat()};
        req_valid = 2'b11;
        n = 0;
        while (grant_log.size() < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        if (grant_log.size() < 4) fail_now("arb_timeout");
        else for (int i = 0; i < 4; i++) check($sformatf("arb_order_%0d", i), grant_log[i], arb_exp[i]);
        drain();

        // randomized traffic with backpressure and withdrawn requests
        rr_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: send(int'($urandom_range(0, 1)), rand_op(), rand_mat(), rand_mat());
                1: send_both(rand_op(), rand_op());
                default: begin
                    send(0, rand_op(), rand_mat(), rand_mat());
                    req_op[5:3] = rand_op();
                    req_a[2*MW-1:MW] = rand_mat();
                    req_b[2*MW-1:MW] = rand_mat();
                    req_valid[1] = 1'b1;
                    repeat (3) @(posedge clk);
                    #1;
                    req_valid[1] = 1'b0;
                end
            endcase
        end
        drain();
        rr_rand = 1'b0;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        // reset during the fourth RUN cycle (cycle 6 after acceptance)
        send(0, 3'd0, rand_mat(), rand_mat());
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_mid_reset");

        // fresh matmul with the response held off for 3 cycles
        resp_ready = 1'b0;
        send(0, 3'd0, ident, seq);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) fail_now("post_reset_resp_timeout");
        repeat (3) @(negedge clk);
        check("held_resp_valid", resp_valid, 1);
        check("held_resp_payload", {resp_id, resp_error, resp_result}, {1'b0, 1'b0, seq});
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();
        check("post_reset_matmul", last_resp, {1'b0, 1'b0, seq});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        fail_now("global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
